// File: rtl/md_pkg.sv
// Shared types and unit opcodes for the multiply-divide issue stage.
package md_pkg;

    // Execute-stage request function codes
    typedef enum logic [2:0] {
        MD_MULT = 3'd0,
        MD_MADD = 3'd1,
        MD_DIV  = 3'd2,
        MD_DIVU = 3'd3,
        MD_MTHI = 3'd4,
        MD_MTLO = 3'd5,
        MD_MFHI = 3'd6,
        MD_MFLO = 3'd7
    } md_func_t;

    // Opcodes understood by the multiply-divide unit
    localparam logic [2:0] MD_OP_MUL  = 3'b000;
    localparam logic [2:0] MD_OP_MAD  = 3'b001;
    localparam logic [2:0] MD_OP_MTLO = 3'b010;
    localparam logic [2:0] MD_OP_MTHI = 3'b110;
    localparam logic [2:0] MD_OP_DIV  = 3'b011;

    // Issue stage states
    typedef enum logic [1:0] {
        ISS_IDLE   = 2'd0,
        ISS_WAIT   = 2'd1,
        ISS_FIX_HI = 2'd2,
        ISS_FIX_LO = 2'd3
    } md_iss_state_t;

endpackage

// File: rtl/md_issue_cond_neg.sv
// 32-bit conditional two's-complement negator (wraps on 0x80000000).
module md_issue_cond_neg (
    input  logic        neg,
    input  logic [31:0] din,
    output logic [31:0] dout
);

    assign dout = neg ? (~din + 32'd1) : din;

endmodule

// File: rtl/md_issue.sv
// Issue/interlock stage in front of the HI/LO multiply-divide unit.
// Signed division runs on the unsigned divider using operand magnitudes;
// the sign of the quotient and remainder is remembered in two flags and
// applied on MFHI/MFLO reads, or written back to HI/LO before a MADD.
module md_issue
    import md_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic [2:0]  FUNC,
    input  logic [31:0] RS,
    input  logic [31:0] RT,
    output logic        STALL,
    output logic [31:0] RESULT,
    output logic        MD_EN,
    output logic [2:0]  MD_OP,
    output logic [31:0] MD_A,
    output logic [31:0] MD_B,
    input  logic [31:0] MD_HI,
    input  logic [31:0] MD_LO,
    input  logic        MD_BUSY
);

    md_iss_state_t state_q, state_d;
    logic          neg_hi_q, neg_hi_d;
    logic          neg_lo_q, neg_lo_d;

    md_func_t      func;
    logic          ready;
    logic          rd_hi;
    logic [31:0]   abs_rs, abs_rt;
    logic [31:0]   rd_raw, rd_val;
    logic [31:0]   fix_raw, fix_val;

    logic          stall_c;
    logic          md_en_c;
    logic [2:0]    md_op_c;
    logic [31:0]   md_a_c, md_b_c, result_c;

    assign func    = md_func_t'(FUNC);
    // WAIT with the unit idle is indistinguishable from IDLE
    assign ready   = (state_q == ISS_IDLE) || ((state_q == ISS_WAIT) && !MD_BUSY);
    assign rd_hi   = (func == MD_MFHI);
    assign rd_raw  = rd_hi ? MD_HI : MD_LO;
    assign fix_raw = (state_q == ISS_FIX_HI) ? MD_HI : MD_LO;

    md_issue_cond_neg u_abs_rs (.neg(RS[31]), .din(RS), .dout(abs_rs));
    md_issue_cond_neg u_abs_rt (.neg(RT[31]), .din(RT), .dout(abs_rt));
    md_issue_cond_neg u_rd_fix (.neg(rd_hi ? neg_hi_q : neg_lo_q), .din(rd_raw), .dout(rd_val));
    md_issue_cond_neg u_wb_neg (.neg(1'b1), .din(fix_raw), .dout(fix_val));

    // Decode requests into unit commands, interlock and next-state/flags
    always_comb begin
        state_d  = state_q;
        neg_hi_d = neg_hi_q;
        neg_lo_d = neg_lo_q;
        stall_c  = 1'b0;
        md_en_c  = 1'b0;
        md_op_c  = 3'b000;
        md_a_c   = 32'd0;
        md_b_c   = 32'd0;
        result_c = 32'd0;
        case (state_q)
            ISS_FIX_HI: begin
                stall_c  = REQ;
                md_en_c  = 1'b1;
                md_op_c  = MD_OP_MTHI;
                md_a_c   = fix_val;
                neg_hi_d = 1'b0;
                state_d  = neg_lo_q ? ISS_FIX_LO : ISS_WAIT;
            end
            ISS_FIX_LO: begin
                stall_c  = 1'b1;
                md_en_c  = 1'b1;
                md_op_c  = MD_OP_MTLO;
                md_a_c   = fix_val;
                neg_lo_d = 1'b0;
                state_d  = ISS_WAIT;
            end
            default: begin
                if (REQ && !ready) begin
                    stall_c = 1'b1;
                end else if (REQ) begin
                    case (func)
                        MD_MULT: begin
                            md_en_c  = 1'b1;
                            md_op_c  = MD_OP_MUL;
                            md_a_c   = RS;
                            md_b_c   = RT;
                            neg_hi_d = 1'b0;
                            neg_lo_d = 1'b0;
                            state_d  = ISS_WAIT;
                        end
                        MD_MADD: begin
                            // Accumulating onto sign-pending HI/LO needs a write-back first
                            if (neg_hi_q || neg_lo_q) begin
                                stall_c = 1'b1;
                                state_d = neg_hi_q ? ISS_FIX_HI : ISS_FIX_LO;
                            end else begin
                                md_en_c = 1'b1;
                                md_op_c = MD_OP_MAD;
                                md_a_c  = RS;
                                md_b_c  = RT;
                                state_d = ISS_WAIT;
                            end
                        end
                        MD_DIV: begin
                            md_en_c  = 1'b1;
                            md_op_c  = MD_OP_DIV;
                            md_a_c   = abs_rs;
                            md_b_c   = abs_rt;
                            neg_lo_d = RS[31] ^ RT[31];
                            neg_hi_d = RS[31];
                            state_d  = ISS_WAIT;
                        end
                        MD_DIVU: begin
                            md_en_c  = 1'b1;
                            md_op_c  = MD_OP_DIV;
                            md_a_c   = RS;
                            md_b_c   = RT;
                            neg_hi_d = 1'b0;
                            neg_lo_d = 1'b0;
                            state_d  = ISS_WAIT;
                        end
                        MD_MTHI: begin
                            md_en_c  = 1'b1;
                            md_op_c  = MD_OP_MTHI;
                            md_a_c   = RS;
                            neg_hi_d = 1'b0;
                            state_d  = ISS_WAIT;
                        end
                        MD_MTLO: begin
                            md_en_c  = 1'b1;
                            md_op_c  = MD_OP_MTLO;
                            md_a_c   = RS;
                            neg_lo_d = 1'b0;
                            state_d  = ISS_WAIT;
                        end
                        default: begin
                            // MFHI / MFLO: sign-corrected read, no unit command
                            result_c = rd_val;
                        end
                    endcase
                end
            end
        endcase
        // Outputs are quiet for as long as reset is held
        if (!RESET) begin
            stall_c  = 1'b0;
            md_en_c  = 1'b0;
            md_op_c  = 3'b000;
            md_a_c   = 32'd0;
            md_b_c   = 32'd0;
            result_c = 32'd0;
        end
    end

    // State and sign flags; reset discards any pending write-back
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ISS_IDLE;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            neg_hi_q <= neg_hi_d;
            neg_lo_q <= neg_lo_d;
        end
    end

    assign STALL  = stall_c;
    assign MD_EN  = md_en_c;
    assign MD_OP  = md_op_c;
    assign MD_A   = md_a_c;
    assign MD_B   = md_b_c;
    assign RESULT = result_c;

endmodule

// File: tb/tb_md_issue.sv
// Directed bench for md_issue with a behavioural multiply-divide unit.
module tb_md_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [2:0]  func;
    logic [31:0] rs, rt;
    logic        stall, md_en, md_busy;
    logic [2:0]  md_op;
    logic [31:0] result, md_a, md_b, md_hi, md_lo;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] cap_result, cap_a, cap_b;
    logic [2:0]  cap_op;
    logic        cap_en;
    int          cap_stalls;

    logic [31:0] log_op[$];
    logic [31:0] log_a[$];

    always #5 clk = ~clk;

    md_issue dut (
        .CLK(clk), .RESET(rst_n), .REQ(req), .FUNC(func), .RS(rs), .RT(rt),
        .STALL(stall), .RESULT(result), .MD_EN(md_en), .MD_OP(md_op),
        .MD_A(md_a), .MD_B(md_b), .MD_HI(md_hi), .MD_LO(md_lo), .MD_BUSY(md_busy)
    );

    // Behavioural unit: registered command, HI/LO kept across reset
    int     busy_cnt = 0;
    longint prod;
    logic [63:0] acc;
    initial begin
        md_hi = 32'd0;
        md_lo = 32'd0;
    end
    assign md_busy = (busy_cnt != 0);

    always @(posedge clk) begin
        if (!rst_n) begin
            busy_cnt <= 0;
        end else begin
            if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
            if (md_en) begin
                log_op.push_back({29'd0, md_op});
                log_a.push_back(md_a);
                prod = longint'($signed(md_a)) * longint'($signed(md_b));
                case (md_op)
                    3'b000: begin
                        {md_hi, md_lo} <= prod;
                        busy_cnt <= 1;
                    end
                    3'b001: begin
                        acc = {md_hi, md_lo} + prod;
                        {md_hi, md_lo} <= acc;
                        busy_cnt <= 1;
                    end
                    3'b011: begin
                        if (md_b == 32'd0) begin
                            md_lo <= 32'hFFFFFFFF;
                            md_hi <= md_a;
                        end else begin
                            md_lo <= md_a / md_b;
                            md_hi <= md_a % md_b;
                        end
                        busy_cnt <= 4;
                    end
                    3'b110: begin md_hi <= md_a; busy_cnt <= 1; end
                    3'b010: begin md_lo <= md_a; busy_cnt <= 1; end
                    default: busy_cnt <= 1;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Present a request until accepted; capture accept-cycle outputs
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        req = 1'b1; func = f; rs = a; rt = b;
        #2;
        while (stall && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (stall) check("accept_timeout", 32'(stall), 32'd0);
        cap_result = result; cap_en = md_en; cap_op = md_op;
        cap_a = md_a; cap_b = md_b; cap_stalls = n;
        $display("txn func=%0d rs=%08h rt=%08h stalls=%0d en=%0b op=%03b a=%08h b=%08h result=%08h",
                 f, a, b, n, cap_en, cap_op, cap_a, cap_b, cap_result);
        @(posedge clk); #1;
        req = 1'b0; func = 3'd0; rs = 32'd0; rt = 32'd0;
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b1; func = 3'd0; rs = 32'd7; rt = 32'd3;
        #3;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_en", 32'(md_en), 32'd0);
        check("rst_a", md_a, 32'd0);
        check("rst_result", result, 32'd0);
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MULT 7 * -3
        issue(3'd0, 32'd7, 32'hFFFFFFFD);
        check("mult_stalls", 32'(cap_stalls), 32'd0);
        check("mult_op", 32'(cap_op), 32'd0);
        check("mult_b", cap_b, 32'hFFFFFFFD);
        #1 check("wait_noreq_stall", 32'(stall), 32'd0);
        issue(3'd7, 32'd0, 32'd0);
        check("mult_mflo_stalls", 32'(cap_stalls), 32'd1);
        check("mult_mflo", cap_result, 32'hFFFFFFEB);
        check("mflo_no_en", 32'(cap_en), 32'd0);
        check("mflo_a_zero", cap_a, 32'd0);
        issue(3'd6, 32'd0, 32'd0);
        check("mult_mfhi", cap_result, 32'hFFFFFFFF);

        // DIV -7 / 2
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        check("div_op", 32'(cap_op), 32'h3);
        check("div_a", cap_a, 32'd7);
        check("div_b", cap_b, 32'd2);
        issue(3'd7, 32'd0, 32'd0);
        check("div_mflo_stalls", 32'(cap_stalls), 32'd4);
        check("div_mflo", cap_result, 32'hFFFFFFFD);
        issue(3'd6, 32'd0, 32'd0);
        check("div_mfhi", cap_result, 32'hFFFFFFFF);

        // DIVU 0xFFFFFFF9 / 2
        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        check("divu_a", cap_a, 32'hFFFFFFF9);
        check("divu_op", 32'(cap_op), 32'h3);
        issue(3'd7, 32'd0, 32'd0);
        check("divu_mflo", cap_result, 32'h7FFFFFFC);
        issue(3'd6, 32'd0, 32'd0);
        check("divu_mfhi", cap_result, 32'h00000001);

        // DIV -7/2 then MADD 1,1: sign write-back before accumulate
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        log_op.delete(); log_a.delete();
        issue(3'd1, 32'd1, 32'd1);
        check("madd_stalls", 32'(cap_stalls), 32'd8);
        check("madd_log_len", 32'(log_op.size()), 32'd3);
        if (log_op.size() == 3) begin
            check("fix_hi_op", log_op[0], 32'h6);
            check("fix_hi_a", log_a[0], 32'hFFFFFFFF);
            check("fix_lo_op", log_op[1], 32'h2);
            check("fix_lo_a", log_a[1], 32'hFFFFFFFD);
            check("madd_op", log_op[2], 32'h1);
        end
        issue(3'd6, 32'd0, 32'd0);
        check("madd_mfhi", cap_result, 32'hFFFFFFFF);
        issue(3'd7, 32'd0, 32'd0);
        check("madd_mflo", cap_result, 32'hFFFFFFFE);

        // DIV -7/2 then MTHI 5: only neg_hi cleared
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        issue(3'd4, 32'd5, 32'd0);
        check("mthi_op", 32'(cap_op), 32'h6);
        check("mthi_a", cap_a, 32'd5);
        issue(3'd6, 32'd0, 32'd0);
        check("mthi_mfhi", cap_result, 32'h00000005);
        issue(3'd7, 32'd0, 32'd0);
        check("mthi_mflo", cap_result, 32'hFFFFFFFD);

        // DIV 0x80000000 / -1: magnitude wrap
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        check("wrap_a", cap_a, 32'h80000000);
        check("wrap_b", cap_b, 32'h00000001);
        issue(3'd7, 32'd0, 32'd0);
        check("wrap_mflo", cap_result, 32'h80000000);
        issue(3'd6, 32'd0, 32'd0);
        check("wrap_mfhi", cap_result, 32'h00000000);

        // DIV then reset during WAIT: flags lost, raw reads afterwards
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        rst_n = 1'b0; req = 1'b1; func = 3'd7;
        #1;
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_en", 32'(md_en), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; req = 1'b0;
        @(posedge clk); #1;
        issue(3'd7, 32'd0, 32'd0);
        check("postrst_stalls", 32'(cap_stalls), 32'd0);
        check("postrst_mflo", cap_result, 32'h00000003);
        issue(3'd6, 32'd0, 32'd0);
        check("postrst_mfhi", cap_result, 32'h00000001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/md_issue.md
# md_issue

Issue and interlock stage directly upstream of the HI/LO multiply-divide unit. It decodes execute-stage multiply/divide requests into unit commands (EN/OP/A/B), stalls the pipeline while the unit is busy, and performs signed division on top of the unit's unsigned divider. It does this by dividing magnitudes and correcting signs on MFHI/MFLO reads, and by writing corrected HI/LO back before any MADD.

## Interface
Parameters: none (datapath fixed at 32 bits).

- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- REQ  in  1  execute-stage request valid
- FUNC  in  3  md_func_t: MULT=0, MADD=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MFHI=6, MFLO=7
- RS  in  32  first operand
- RT  in  32  second operand
- STALL  out  1  request not accepted this cycle; pipeline holds REQ/FUNC/RS/RT
- RESULT  out  32  MFHI/MFLO data, valid in the accept cycle
- MD_EN  out  1  command strobe to multiply-divide unit
- MD_OP  out  3  unit opcode: MUL=000, MAD=001, MTLO=010, MTHI=110, DIV=011
- MD_A  out  32  unit operand A
- MD_B  out  32  unit operand B
- MD_HI  in  32  unit HI register
- MD_LO  in  32  unit LO register
- MD_BUSY  in  1  unit busy

## Operation
- A request is accepted in a cycle with REQ=1 and STALL=0. STALL is combinational from REQ, FUNC, state and flags.
- Flags:
  - neg_hi: HI holds the magnitude of a negative remainder.
  - neg_lo: LO holds the magnitude of a negative quotient.
- States:
  - IDLE: ready to accept.
  - WAIT: unit busy.
  - FIX_HI and FIX_LO: sign write-back before a MADD.
- "Ready" means IDLE, or WAIT with MD_BUSY=0 (WAIT then behaves exactly as IDLE).
- When ready and REQ=1:
  - MULT/MADD: MD_EN=1, MD_A=RS, MD_B=RT, op MUL or MAD; next state WAIT. MULT clears both flags.
  - MADD with any flag set: not accepted; STALL=1; next state FIX_HI if neg_hi, else FIX_LO.
  - DIVU: MD_EN=1, op DIV, operands unchanged, clears both flags; next state WAIT.
  - DIV: MD_EN=1, op DIV, MD_A=|RS|, MD_B=|RT| (0x80000000 passes as its unsigned magnitude). Sets neg_lo=RS[31]^RT[31] and neg_hi=RS[31]; next state WAIT. Divide by zero gets no special handling: flags are computed as above.
  - MTHI/MTLO: MD_EN=1, op MTHI/MTLO, MD_A=RS; clears neg_hi (MTHI) or neg_lo (MTLO); next state WAIT.
  - MFHI: accepted; RESULT = neg_hi ? -MD_HI : MD_HI. MFLO works the same with neg_lo and MD_LO. No unit command; state unchanged (IDLE).
- Not ready and REQ=1: STALL=1. With REQ=0, STALL=0.
- FIX_HI: STALL=REQ (always 1 here); MD_EN=1, op MTHI, MD_A=-MD_HI; clear neg_hi; next state FIX_LO if neg_lo, else WAIT.
- FIX_LO: STALL=1; MD_EN=1, op MTLO, MD_A=-MD_LO; clear neg_lo; next state WAIT. The held MADD is then accepted from WAIT once MD_BUSY=0.
- When MD_EN=0: MD_OP, MD_A, MD_B and RESULT (when not reading) are driven 0.
- Arithmetic: negation is 32-bit two's complement, and wrap is allowed (-0x80000000 = 0x80000000).

## Timing
- Reset values:
  - state IDLE, both flags 0.
  - STALL=0, MD_EN=0, MD_OP=0, MD_A=0, MD_B=0, RESULT=0.
- Reset asserted mid-WAIT or mid-FIX: the block returns to IDLE immediately and any pending write-back is lost (the unit is reset by the same source).
- MD_BUSY is registered in the unit and goes high the cycle after MD_EN. The first WAIT cycle therefore always stalls.
- Latency, command accepted at t:
  - MULT/MADD/MT: dependent MFHI/MFLO is accepted at t+2.
  - DIV/DIVU: the dependent read is accepted in the first cycle MD_BUSY=0 in WAIT.
- FIX_HI and FIX_LO issue in consecutive cycles. The unit's registered opcode makes back-to-back MT writes correct.
- A MADD blocked by flags has latency: 1 stall cycle + 1 or 2 FIX cycles + WAIT.

## Structure
- Shared package md_pkg holds:
  - md_func_t (3-bit enum);
  - MD_OP constants: MD_OP_MUL, MD_OP_MAD, MD_OP_MTLO, MD_OP_MTHI, MD_OP_DIV;
  - state enum md_iss_state_t.
- One sub-module is natural: cond_neg (32-bit conditional two's-complement negator), instantiated for |RS|, |RT|, the read correction and the fix write-back.

## Test plan
- MULT RS=7, RT=0xFFFFFFFD accepted at t; MFLO at t+1 -> STALL=1, accepted t+2 with RESULT=0xFFFFFFEB; then MFHI -> 0xFFFFFFFF.
- DIV RS=0xFFFFFFF9 (-7), RT=2 -> MD_A=7, MD_B=2, MD_OP=011; after MD_BUSY falls, MFLO -> 0xFFFFFFFD, MFHI -> 0xFFFFFFFF.
- DIVU RS=0xFFFFFFF9, RT=2 -> MD_A unchanged; MFLO -> 0x7FFFFFFC, MFHI -> 0x00000001.
- DIV -7/2, then MADD 1,1 -> STALL held, then:
  - MD_EN op 110 with A=0xFFFFFFFF;
  - next cycle op 010 with A=0xFFFFFFFD;
  - then op 001 accepted;
  - MFHI -> 0xFFFFFFFF, MFLO -> 0xFFFFFFFE.
- DIV -7/2, then MTHI RS=5 -> MFHI -> 0x00000005, MFLO -> 0xFFFFFFFD (neg_lo retained).
- DIV issued, RESET low during WAIT -> STALL=0, MD_EN=0, flags 0 in the same cycle; MFLO after release returns raw MD_LO.
